alu_instr_sequencer: RTL
========================

Name: alu_instr_sequencer

Overview:
- Hardwired control unit for the 32-bit datapath. It generates the one-cycle-per-step control strobes for instruction fetch (T0–T2) and for execution (T3–T6) of register-register ALU, mul/div and neg/not instructions.
- It replaces the hand-driven control sequences in the datapath benches. Outputs connect one-to-one to the datapath control inputs.
- The instruction comes from the datapath IR output, decoded as opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- run  in  1  1 = fetch and execute continuously; sampled in IDLE and at instruction end.
- mem_rdy  in  1  memory read data valid; completes T1.
- ir  in  32  datapath IR contents; valid from T3 onward.
- r_out  out  16  one-hot register drive enables; bit n = Rnout.
- r_in  out  16  one-hot register load enables; bit n = Rnin.
- pc_out, zlow_out, zhigh_out, mdr_out  out  1 each  bus drive strobes.
- mar_in, pc_in, mdr_in, ir_in, y_in, z_in, lo_in, hi_in  out  1 each  load strobes.
- inc_pc, read  out  1 each  PC increment, memory read.
- alu_op  out  13  one-hot ALU select; bit0..12 = AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
- done  out  1  one-cycle pulse in the final execute step.
- illegal  out  1  sticky; unsupported opcode decoded.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; registered state.
- Strobes are Moore outputs decoded from state and ir. Anything not listed for a step is 0.
- Reset (async, any time, including mid-instruction): state=IDLE, all strobes 0, done=0, illegal=0, instr_count=0.
- IDLE: no strobes. Goes to T0 when run=1, else stays.
- T0: pc_out, mar_in, inc_pc, z_in. Next state T1.
- T1: zlow_out, pc_in, read, mdr_in.
  - Stays in T1 while mem_rdy=0, all four strobes held. Z is unchanged, so repeated PC loads are idempotent.
  - Goes to T2 in the cycle mem_rdy=1.
- T2: mdr_out, ir_in. Next state T3.
- Opcode classes (decimal):
  - RR = 3 ADD, 4 SUB, 5 AND, 6 OR, 7 ROR, 8 ROL, 9 SHR, 10 SHRA, 11 SHL.
  - MD = 15 MUL, 16 DIV.
  - UN = 17 NEG, 18 NOT.
  - Any other opcode → HALT from T3, no T3 strobes, illegal set to 1.
- RR sequence:
  - T3: r_out[Rb], y_in.
  - T4: r_out[Rc], alu_op[op], z_in.
  - T5: zlow_out, r_in[Ra], done.
- MD sequence:
  - T3: r_out[Ra], y_in.
  - T4: r_out[Rb], alu_op[op], z_in.
  - T5: zlow_out, lo_in.
  - T6: zhigh_out, hi_in, done.
- UN sequence:
  - T3: r_out[Rb], alu_op[op], z_in.
  - T4: zlow_out, r_in[Ra], done.
- Instruction end (the done cycle):
  - instr_count increments at the following edge.
  - Next state is T0 if run=1, else IDLE.
  - Deasserting run mid-instruction does not abort the instruction.
- HALT: all strobes 0; left only by reset.
- Invariants:
  - At most one bus driver active per cycle: r_out, pc_out, zlow_out, zhigh_out and mdr_out are mutually exclusive.
  - r_out and r_in are each zero or one-hot.
  - Ra=Rb=Rc is legal.
- Latency: RR and UN instructions take 6 and 5 cycles plus T1 wait cycles; MD takes 7 plus wait cycles.

Test Plan:
- SHL: run=1, mem_rdy=1, ir=32'h5A1B8000 (op 11, Ra=4, Rb=3, Rc=7) → T3 r_out=0x0008 with y_in; T4 r_out=0x0080 with alu_op=0x0100 and z_in; T5 zlow_out with r_in=0x0010 and done; instr_count 0→1; next state T0.
- Memory wait: mem_rdy low for 3 cycles in T1 → read and mdr_in high for 4 cycles, ir_in exactly 1 cycle after mem_rdy rises, no extra inc_pc.
- MUL: ir=32'h7A1B8000 (op 15, Ra=4, Rb=3) → T3 r_out=0x0010; T4 r_out=0x0008 with alu_op=0x0010; T5 lo_in; T6 hi_in with zhigh_out and done.
- NOT and run drop: ir=32'h92180000 (op 18, Ra=4, Rb=3) with run deasserted during T3 → T3 alu_op=0x1000 with r_out=0x0008; T4 r_in=0x0010 with done; then IDLE, no further T0.
- Illegal: op 31 → HALT, illegal=1, all strobes 0 for 10 cycles; reset pulse → IDLE, illegal=0.
- Async reset mid-T4 (between clock edges) → strobes and instr_count go to 0 immediately, without waiting for a clock edge; restart fetches normally.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// Hardwired control unit for the 32-bit ALU datapath.
// Emits one-cycle fetch (T0-T2) and execute (T3-T6) strobes for RR, MD and UN ops.
module alu_instr_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             mem_rdy,
    input  logic [31:0]      ir,
    output logic [15:0]      r_out,
    output logic [15:0]      r_in,
    output logic             pc_out,
    output logic             zlow_out,
    output logic             zhigh_out,
    output logic             mdr_out,
    output logic             mar_in,
    output logic             pc_in,
    output logic             mdr_in,
    output logic             ir_in,
    output logic             y_in,
    output logic             z_in,
    output logic             lo_in,
    output logic             hi_in,
    output logic             inc_pc,
    output logic             read,
    output logic [12:0]      alu_op,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t state, state_nxt, end_nxt;

    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic        is_rr, is_md, is_un;
    logic [12:0] alu_sel;
    logic        unused_ir;

    assign op        = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];
    assign end_nxt   = run ? T0 : IDLE;

    function automatic logic [15:0] oh(input logic [3:0] n);
        oh = 16'd1 << n;
    endfunction

    always_comb begin
        is_rr   = 1'b0;
        is_md   = 1'b0;
        is_un   = 1'b0;
        alu_sel = '0;
        unique case (op)
            5'd3:    begin is_rr = 1'b1; alu_sel[2]  = 1'b1; end
            5'd4:    begin is_rr = 1'b1; alu_sel[3]  = 1'b1; end
            5'd5:    begin is_rr = 1'b1; alu_sel[0]  = 1'b1; end
            5'd6:    begin is_rr = 1'b1; alu_sel[1]  = 1'b1; end
            5'd7:    begin is_rr = 1'b1; alu_sel[9]  = 1'b1; end
            5'd8:    begin is_rr = 1'b1; alu_sel[10] = 1'b1; end
            5'd9:    begin is_rr = 1'b1; alu_sel[6]  = 1'b1; end
            5'd10:   begin is_rr = 1'b1; alu_sel[7]  = 1'b1; end
            5'd11:   begin is_rr = 1'b1; alu_sel[8]  = 1'b1; end
            5'd15:   begin is_md = 1'b1; alu_sel[4]  = 1'b1; end
            5'd16:   begin is_md = 1'b1; alu_sel[5]  = 1'b1; end
            5'd17:   begin is_un = 1'b1; alu_sel[11] = 1'b1; end
            5'd18:   begin is_un = 1'b1; alu_sel[12] = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        r_out     = '0;
        r_in      = '0;
        pc_out    = 1'b0;
        zlow_out  = 1'b0;
        zhigh_out = 1'b0;
        mdr_out   = 1'b0;
        mar_in    = 1'b0;
        pc_in     = 1'b0;
        mdr_in    = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        lo_in     = 1'b0;
        hi_in     = 1'b0;
        inc_pc    = 1'b0;
        read      = 1'b0;
        alu_op    = '0;
        done      = 1'b0;
        unique case (state)
            IDLE: if (run) state_nxt = T0;
            T0: begin
                pc_out    = 1'b1;
                mar_in    = 1'b1;
                inc_pc    = 1'b1;
                z_in      = 1'b1;
                state_nxt = T1;
            end
            // Z is stable while waiting, so reloading PC each cycle is harmless
            T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
                if (mem_rdy) state_nxt = T2;
            end
            T2: begin
                mdr_out   = 1'b1;
                ir_in     = 1'b1;
                state_nxt = T3;
            end
            T3: unique case (1'b1)
                is_rr: begin
                    r_out     = oh(rb);
                    y_in      = 1'b1;
                    state_nxt = T4;
                end
                is_md: begin
                    r_out     = oh(ra);
                    y_in      = 1'b1;
                    state_nxt = T4;
                end
                is_un: begin
                    r_out     = oh(rb);
                    alu_op    = alu_sel;
                    z_in      = 1'b1;
                    state_nxt = T4;
                end
                default: state_nxt = HALT;
            endcase
            T4: unique case (1'b1)
                is_rr: begin
                    r_out     = oh(rc);
                    alu_op    = alu_sel;
                    z_in      = 1'b1;
                    state_nxt = T5;
                end
                is_md: begin
                    r_out     = oh(rb);
                    alu_op    = alu_sel;
                    z_in      = 1'b1;
                    state_nxt = T5;
                end
                is_un: begin
                    zlow_out  = 1'b1;
                    r_in      = oh(ra);
                    done      = 1'b1;
                    state_nxt = end_nxt;
                end
                default: state_nxt = HALT;
            endcase
            T5: unique case (1'b1)
                is_rr: begin
                    zlow_out  = 1'b1;
                    r_in      = oh(ra);
                    done      = 1'b1;
                    state_nxt = end_nxt;
                end
                is_md: begin
                    zlow_out  = 1'b1;
                    lo_in     = 1'b1;
                    state_nxt = T6;
                end
                default: state_nxt = HALT;
            endcase
            T6: begin
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
                done      = 1'b1;
                state_nxt = end_nxt;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == HALT) illegal <= 1'b1;
            if (done) instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule
